// File: rtl/pcie_status_pkg.sv
// rtl/pcie_status_pkg.sv - LTSSM codes, speed encodings and link FSM states for the PCIe status monitor
package pcie_status_pkg;

  localparam logic [4:0] LTSSM_L0         = 5'h0F;
  localparam logic [4:0] LTSSM_POLL_COMPL = 5'h03;
  localparam logic [4:0] LTSSM_RCVRY_LOCK = 5'h0C;
  localparam logic [4:0] LTSSM_RCVRY_CFG  = 5'h0D;
  localparam logic [4:0] LTSSM_RCVRY_IDLE = 5'h0E;

  localparam logic [1:0] SPEED_GEN1 = 2'd0;
  localparam logic [1:0] SPEED_GEN2 = 2'd1;
  localparam logic [1:0] SPEED_GEN3 = 2'd2;
  localparam logic [1:0] SPEED_RSVD = 2'd3;

  typedef enum logic [1:0] {
    LINK_DOWN    = 2'd0,
    LINK_QUALIFY = 2'd1,
    LINK_UP      = 2'd2,
    LINK_LOST    = 2'd3
  } link_state_e;

  // Recovery excursions are part of normal operation and must not drop the link.
  function automatic logic ltssm_holds_link(input logic [4:0] code);
    return (code == LTSSM_L0) || (code == LTSSM_RCVRY_LOCK) ||
           (code == LTSSM_RCVRY_CFG) || (code == LTSSM_RCVRY_IDLE);
  endfunction

endpackage

// File: rtl/pcie_rst_sync.sv
// rtl/pcie_rst_sync.sv - two-flop reset synchroniser, asynchronous assert and synchronous release
module pcie_rst_sync (
  input  logic clk_out_buf,
  input  logic any_rstn,
  output logic rstn_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_out_buf or negedge any_rstn) begin
    if (!any_rstn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rstn_sync = sync_q[1];

endmodule

// File: rtl/pcie_link_status_monitor.sv
// rtl/pcie_link_status_monitor.sv - debounced PCIe link-up, link-down statistics, training time and LED drives
module pcie_link_status_monitor
  import pcie_status_pkg::*;
#(
  parameter int LANE_CODE_W      = 4,
  parameter int ALIVE_CNT_W      = 26,
  parameter int BLINK_SLOW_BIT   = 24,
  parameter int BLINK_FAST_BIT   = 22,
  parameter int L0_STABLE_CYCLES = 1024,
  parameter int LINKDOWN_CNT_W   = 8,
  parameter int TRAIN_CNT_W      = 24,
  parameter bit LED_ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk_out_buf,
  input  logic                      any_rstn,
  input  logic [4:0]                ltssm_state,
  input  logic [LANE_CODE_W-1:0]    lane_act_code,
  input  logic [1:0]                speed,
  input  logic                      clear_counters,
  output logic                      link_up,
  output logic                      link_down_sticky,
  output logic [LINKDOWN_CNT_W-1:0] linkdown_cnt,
  output logic [TRAIN_CNT_W-1:0]    train_time_cnt,
  output logic                      alive_led,
  output logic                      comp_led,
  output logic                      l0_led,
  output logic                      speed_led,
  output logic [LANE_CODE_W-1:0]    lane_active_led
);

  localparam int STABLE_W = $clog2(L0_STABLE_CYCLES + 1);
  localparam logic [STABLE_W-1:0]       STABLE_TARGET = STABLE_W'(L0_STABLE_CYCLES);
  localparam logic [STABLE_W-1:0]       STABLE_ONE    = STABLE_W'(1);
  localparam logic [LINKDOWN_CNT_W-1:0] LD_MAX        = '1;
  localparam logic [LINKDOWN_CNT_W-1:0] LD_ONE        = LINKDOWN_CNT_W'(1);
  localparam logic [TRAIN_CNT_W-1:0]    TRAIN_MAX     = '1;
  localparam logic                      LED_OFF       = LED_ACTIVE_LOW;

  function automatic logic led_level(input logic on);
    return on ^ LED_OFF;
  endfunction

  logic rstn_sync;

  pcie_rst_sync u_rst_sync (
    .clk_out_buf (clk_out_buf),
    .any_rstn    (any_rstn),
    .rstn_sync   (rstn_sync)
  );

  logic [4:0]                ltssm_s1_q, ltssm_s1_d;
  logic [LANE_CODE_W-1:0]    lane_s1_q, lane_s1_d;
  logic [1:0]                speed_s1_q, speed_s1_d;
  link_state_e               state_q, state_d;
  logic [STABLE_W-1:0]       stable_cnt_q, stable_cnt_d;
  logic                      link_up_q, link_up_d;
  logic                      sticky_q, sticky_d;
  logic [LINKDOWN_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [TRAIN_CNT_W-1:0]    train_q, train_d;
  logic                      seen_up_q, seen_up_d;
  logic [ALIVE_CNT_W-1:0]    alive_cnt_q, alive_cnt_d;
  logic                      alive_led_q, alive_led_d;
  logic                      comp_led_q, comp_led_d;
  logic                      l0_led_q, l0_led_d;
  logic                      speed_led_q, speed_led_d;
  logic [LANE_CODE_W-1:0]    lane_led_q, lane_led_d;
  logic [STABLE_W-1:0]       stable_inc;
  logic                      speed_on;

  always_comb begin
    ltssm_s1_d   = ltssm_state;
    lane_s1_d    = lane_act_code;
    speed_s1_d   = speed;
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    stable_inc   = stable_cnt_q + 1'b1;
    case (state_q)
      LINK_DOWN: begin
        if (ltssm_s1_q == LTSSM_L0) begin
          state_d      = LINK_QUALIFY;
          stable_cnt_d = STABLE_ONE;
        end
      end
      LINK_QUALIFY: begin
        if (ltssm_s1_q != LTSSM_L0) begin
          state_d      = LINK_DOWN;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_inc;
          if (stable_inc == STABLE_TARGET) begin
            state_d = LINK_UP;
          end
        end
      end
      LINK_UP: begin
        if (!ltssm_holds_link(ltssm_s1_q)) begin
          state_d = LINK_LOST;
        end
      end
      default: begin
        state_d = LINK_DOWN;
      end
    endcase
    link_up_d = (state_d == LINK_UP);
  end

  // A loss event takes priority over a coincident clear so no drop goes unrecorded.
  always_comb begin
    sticky_d = sticky_q;
    ld_cnt_d = ld_cnt_q;
    if (state_q == LINK_LOST) begin
      sticky_d = 1'b1;
      if (clear_counters) begin
        ld_cnt_d = LD_ONE;
      end else if (ld_cnt_q != LD_MAX) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
    end else if (clear_counters) begin
      sticky_d = 1'b0;
      ld_cnt_d = '0;
    end
    train_d   = train_q;
    seen_up_d = seen_up_q | (state_d == LINK_UP);
    if (!seen_up_q && (train_q != TRAIN_MAX)) begin
      train_d = train_q + 1'b1;
    end
    alive_cnt_d = alive_cnt_q + 1'b1;
  end

  always_comb begin
    speed_on = 1'b0;
    if (link_up_q) begin
      case (speed_s1_q)
        SPEED_GEN1: speed_on = 1'b1;
        SPEED_GEN2: speed_on = alive_cnt_q[BLINK_SLOW_BIT];
        SPEED_GEN3: speed_on = alive_cnt_q[BLINK_FAST_BIT];
        default:    speed_on = 1'b0;
      endcase
    end
    alive_led_d = led_level(alive_cnt_q[ALIVE_CNT_W-1]);
    comp_led_d  = led_level(ltssm_s1_q == LTSSM_POLL_COMPL);
    l0_led_d    = led_level(link_up_d);
    speed_led_d = led_level(speed_on);
    lane_led_d  = lane_s1_q ^ {LANE_CODE_W{LED_OFF}};
  end

  always_ff @(posedge clk_out_buf or negedge rstn_sync) begin
    if (!rstn_sync) begin
      ltssm_s1_q   <= '0;
      lane_s1_q    <= '0;
      speed_s1_q   <= '0;
      state_q      <= LINK_DOWN;
      stable_cnt_q <= '0;
      link_up_q    <= 1'b0;
      sticky_q     <= 1'b0;
      ld_cnt_q     <= '0;
      train_q      <= '0;
      seen_up_q    <= 1'b0;
      alive_cnt_q  <= '0;
      alive_led_q  <= LED_OFF;
      comp_led_q   <= LED_OFF;
      l0_led_q     <= LED_OFF;
      speed_led_q  <= LED_OFF;
      lane_led_q   <= {LANE_CODE_W{LED_OFF}};
    end else begin
      ltssm_s1_q   <= ltssm_s1_d;
      lane_s1_q    <= lane_s1_d;
      speed_s1_q   <= speed_s1_d;
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      link_up_q    <= link_up_d;
      sticky_q     <= sticky_d;
      ld_cnt_q     <= ld_cnt_d;
      train_q      <= train_d;
      seen_up_q    <= seen_up_d;
      alive_cnt_q  <= alive_cnt_d;
      alive_led_q  <= alive_led_d;
      comp_led_q   <= comp_led_d;
      l0_led_q     <= l0_led_d;
      speed_led_q  <= speed_led_d;
      lane_led_q   <= lane_led_d;
    end
  end

  assign link_up          = link_up_q;
  assign link_down_sticky = sticky_q;
  assign linkdown_cnt     = ld_cnt_q;
  assign train_time_cnt   = train_q;
  assign alive_led        = alive_led_q;
  assign comp_led         = comp_led_q;
  assign l0_led           = l0_led_q;
  assign speed_led        = speed_led_q;
  assign lane_active_led  = lane_led_q;

endmodule

// File: tb/tb_pcie_link_status_monitor.sv
// tb/tb_pcie_link_status_monitor.sv - self-checking bench for pcie_link_status_monitor
module tb_pcie_link_status_monitor;
  import pcie_status_pkg::*;

  localparam int LW = 4;
  localparam int LDW = 2;
  localparam int TW = 24;

  logic            clk_out_buf = 1'b0;
  logic            any_rstn;
  logic [4:0]      ltssm_state;
  logic [LW-1:0]   lane_act_code;
  logic [1:0]      speed;
  logic            clear_counters;
  logic            link_up;
  logic            link_down_sticky;
  logic [LDW-1:0]  linkdown_cnt;
  logic [TW-1:0]   train_time_cnt;
  logic            alive_led;
  logic            comp_led;
  logic            l0_led;
  logic            speed_led;
  logic [LW-1:0]   lane_active_led;

  typedef struct {
    int            due;
    logic [LW-1:0] lane;
    logic          comp;
  } led_exp_t;

  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       rel_cyc = 0;
  int       train_exp = 0;
  led_exp_t led_q[$];
  int       ld_q[$];

  pcie_link_status_monitor #(
    .LANE_CODE_W      (LW),
    .ALIVE_CNT_W      (8),
    .BLINK_SLOW_BIT   (5),
    .BLINK_FAST_BIT   (3),
    .L0_STABLE_CYCLES (16),
    .LINKDOWN_CNT_W   (LDW),
    .TRAIN_CNT_W      (TW),
    .LED_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_out_buf      (clk_out_buf),
    .any_rstn         (any_rstn),
    .ltssm_state      (ltssm_state),
    .lane_act_code    (lane_act_code),
    .speed            (speed),
    .clear_counters   (clear_counters),
    .link_up          (link_up),
    .link_down_sticky (link_down_sticky),
    .linkdown_cnt     (linkdown_cnt),
    .train_time_cnt   (train_time_cnt),
    .alive_led        (alive_led),
    .comp_led         (comp_led),
    .l0_led           (l0_led),
    .speed_led        (speed_led),
    .lane_active_led  (lane_active_led)
  );

  always #5 clk_out_buf = ~clk_out_buf;
  always @(posedge clk_out_buf) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk_out_buf);
  endtask

  task automatic test_reset();
    logic [7:0] leds;
    any_rstn = 1'b0; ltssm_state = 5'h00; lane_act_code = '0; speed = 2'd0; clear_counters = 1'b0;
    step(3);
    checks++;
    if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b want 0", link_up); end
    leds = {alive_led, comp_led, l0_led, speed_led, lane_active_led};
    checks++;
    if (leds !== 8'hFF) begin errors++; $display("FAIL reset_leds: got %h want ff", leds); end
    checks++;
    if ({link_down_sticky, linkdown_cnt, train_time_cnt} !== '0) begin
      errors++; $display("FAIL reset_counters: sticky=%b cnt=%0d train=%0d want all 0", link_down_sticky, linkdown_cnt, train_time_cnt);
    end
    any_rstn = 1'b1;
    rel_cyc = cyc;
    step(2);
    checks++;
    if (train_time_cnt !== 24'd0) begin errors++; $display("FAIL train_hold_sync: got %0d want 0", train_time_cnt); end
    step(1);
    checks++;
    if (train_time_cnt !== 24'd1) begin errors++; $display("FAIL train_first: got %0d want 1", train_time_cnt); end
    step(1);
    checks++;
    if (train_time_cnt !== 24'd2) begin errors++; $display("FAIL train_second: got %0d want 2", train_time_cnt); end
  endtask

  task automatic test_qualify_glitch();
    int bad = 0;
    ltssm_state = LTSSM_L0;
    for (int n = 0; n < 10; n++) begin step(1); if (link_up !== 1'b0) bad++; end
    ltssm_state = 5'h02;
    step(1);
    if (link_up !== 1'b0) bad++;
    ltssm_state = LTSSM_L0;
    for (int n = 1; n <= 16; n++) begin step(1); if (link_up !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL qualify_early: link_up high in %0d cycles want 0", bad); end
    step(1);
    checks++;
    if (link_up !== 1'b1) begin errors++; $display("FAIL qualify_up: got %b want 1", link_up); end
    train_exp = cyc - rel_cyc - 2;
    checks++;
    if (train_time_cnt !== TW'(train_exp)) begin
      errors++; $display("FAIL train_at_up: got %0d want %0d", train_time_cnt, train_exp);
    end
    step(6);
    checks++;
    if (train_time_cnt !== TW'(train_exp)) begin
      errors++; $display("FAIL train_frozen: got %0d want %0d", train_time_cnt, train_exp);
    end
    checks++;
    if (l0_led !== 1'b0) begin errors++; $display("FAIL l0_led_on: got %b want 0", l0_led); end
  endtask

  task automatic test_recovery();
    logic [4:0] codes [4];
    int bad = 0;
    codes = '{LTSSM_RCVRY_LOCK, LTSSM_RCVRY_CFG, LTSSM_RCVRY_IDLE, LTSSM_L0};
    for (int i = 0; i < 4; i++) begin
      ltssm_state = codes[i];
      step(3);
      if (link_up !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || linkdown_cnt !== 2'd0) begin
      errors++; $display("FAIL recovery_hold: drops=%0d cnt=%0d want 0 and 0", bad, linkdown_cnt);
    end
    ltssm_state = 5'h00;
    step(3);
    checks++;
    if ({link_up, link_down_sticky, linkdown_cnt} !== {1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL lost_event: up=%b sticky=%b cnt=%0d want 0 1 1", link_up, link_down_sticky, linkdown_cnt);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt = 0;
    int got_exp;
    int bad_up = 0;
    clear_counters = 1'b1;
    step(1);
    clear_counters = 1'b0;
    checks++;
    if ({link_down_sticky, linkdown_cnt} !== 3'b000) begin
      errors++; $display("FAIL clear: sticky=%b cnt=%0d want 0 0", link_down_sticky, linkdown_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      ltssm_state = LTSSM_L0;
      step(19);
      if (link_up !== 1'b1) bad_up++;
      ltssm_state = 5'h00;
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      ld_q.push_back(exp_cnt);
      step(4);
      got_exp = ld_q.pop_front();
      checks++;
      if (linkdown_cnt !== LDW'(got_exp)) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, linkdown_cnt, got_exp);
      end
    end
    checks++;
    if (bad_up != 0) begin errors++; $display("FAIL sat_link_up: missed %0d want 0", bad_up); end
  endtask

  task automatic test_clear_on_lost();
    ltssm_state = LTSSM_L0;
    step(19);
    ltssm_state = 5'h00;
    step(2);
    checks++;
    if (link_up !== 1'b0) begin errors++; $display("FAIL lost_entry: got %b want 0", link_up); end
    clear_counters = 1'b1;
    step(1);
    clear_counters = 1'b0;
    checks++;
    if ({link_down_sticky, linkdown_cnt} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL clear_vs_lost: sticky=%b cnt=%0d want 1 1", link_down_sticky, linkdown_cnt);
    end
    step(2);
    checks++;
    if (linkdown_cnt !== 2'd1) begin errors++; $display("FAIL clear_vs_lost_hold: got %0d want 1", linkdown_cnt); end
  endtask

  task automatic test_led_latency();
    logic [4:0]    codes [6];
    logic [LW-1:0] lanes [6];
    led_exp_t      e;
    codes = '{5'h03, 5'h00, 5'h03, 5'h01, 5'h02, 5'h03};
    lanes = '{4'b0101, 4'hA, 4'hF, 4'h0, 4'h1, 4'h8};
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        ltssm_state = codes[i];
        lane_act_code = lanes[i];
        e.due = cyc + 2;
        e.lane = ~lanes[i];
        e.comp = (codes[i] == LTSSM_POLL_COMPL) ? 1'b0 : 1'b1;
        led_q.push_back(e);
      end
      step(1);
      while (led_q.size() > 0 && led_q[0].due == cyc) begin
        e = led_q.pop_front();
        checks++;
        if (lane_active_led !== e.lane || comp_led !== e.comp) begin
          errors++; $display("FAIL led_latency: lane=%b comp=%b want %b %b", lane_active_led, comp_led, e.lane, e.comp);
        end
      end
    end
    checks++;
    if (led_q.size() != 0) begin errors++; $display("FAIL led_drain: left %0d want 0", led_q.size()); end
    ltssm_state = 5'h00;
    lane_act_code = '0;
  endtask

  task automatic test_speed();
    int   last_t = -1;
    int   ndiff = 0;
    int   bad = 0;
    logic prev;
    speed = 2'd2;
    ltssm_state = LTSSM_L0;
    step(19);
    checks++;
    if (link_up !== 1'b1) begin errors++; $display("FAIL speed_link_up: got %b want 1", link_up); end
    prev = speed_led;
    for (int t = 1; t <= 48; t++) begin
      step(1);
      if (speed_led !== prev) begin
        if (last_t >= 0) begin ndiff++; if (t - last_t != 8) bad++; end
        last_t = t;
        prev = speed_led;
      end
    end
    checks++;
    if (bad != 0 || ndiff < 4) begin
      errors++; $display("FAIL gen3_blink: bad_periods=%0d periods=%0d want 0 and >=4", bad, ndiff);
    end
    speed = 2'd3;
    step(3);
    bad = 0;
    for (int t = 0; t < 8; t++) begin step(1); if (speed_led !== 1'b1) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL speed_rsvd_off: on in %0d cycles want 0", bad); end
    speed = 2'd0;
    step(3);
    checks++;
    if (speed_led !== 1'b0) begin errors++; $display("FAIL gen1_solid: got %b want 0", speed_led); end
  endtask

  task automatic test_reset_midop();
    any_rstn = 1'b0;
    #1;
    checks++;
    if ({link_up, l0_led, linkdown_cnt} !== {1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL midop_reset: up=%b l0=%b cnt=%0d want 0 1 0", link_up, l0_led, linkdown_cnt);
    end
    ltssm_state = 5'h00;
    step(2);
    any_rstn = 1'b1;
    rel_cyc = cyc;
    step(6);
    checks++;
    if ({link_up, link_down_sticky, linkdown_cnt} !== 4'b0000) begin
      errors++; $display("FAIL midop_no_lost: up=%b sticky=%b cnt=%0d want 0 0 0", link_up, link_down_sticky, linkdown_cnt);
    end
    checks++;
    if (train_time_cnt !== TW'(cyc - rel_cyc - 2)) begin
      errors++; $display("FAIL midop_train: got %0d want %0d", train_time_cnt, cyc - rel_cyc - 2);
    end
  endtask

  initial begin
    test_reset();
    test_qualify_glitch();
    test_recovery();
    test_saturation();
    test_clear_on_lost();
    test_led_latency();
    test_speed();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
